vga_timing_controller: RTL and testbench

//  Sequences the VGA raster: divides Clk into a pixel tick and steps horizontal and

---
 rtl/vga_timing_controller.sv | 174 +++++++++++++++++
 tb/tb_vga_timing_controller.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/vga_timing_controller.sv
// VGA raster sequencer: divides Clk into a pixel tick and steps horizontal and
// vertical ACTIVE/FRONT/SYNC/BACK phase FSMs, presenting registered sync, blank and coordinates.
module vga_timing_controller #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned HW       = 11,
  parameter int unsigned VW       = 10
) (
  input  logic          Clk,
  input  logic          Reset,
  output logic          o_pixel_tick,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_video_on,
  output logic [HW-1:0] o_pixel_x,
  output logic [VW-1:0] o_pixel_y,
  output logic          o_line_start,
  output logic          o_frame_start
);

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  localparam int unsigned DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_MAX = max4(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_MAX = max4(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HCW   = (H_MAX > 1) ? $clog2(H_MAX) : 1;
  localparam int unsigned VCW   = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_FRONT  = 2'd1;
  localparam logic [1:0] ST_SYNC   = 2'd2;
  localparam logic [1:0] ST_BACK   = 2'd3;

  generate
    if (CLK_DIV == 0 || H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 || HW == 0 || VW == 0) begin : g_bad_param
      $error("vga_timing_controller: every parameter must be >= 1");
    end
  endgenerate

  logic [DW-1:0]  r_div;
  logic [1:0]     r_h_state, r_v_state;
  logic [HCW-1:0] r_h_cnt;
  logic [VCW-1:0] r_v_cnt;
  logic           r_pixel_tick, r_hsync, r_vsync, r_video_on, r_line_start, r_frame_start;
  logic [HW-1:0]  r_pixel_x;
  logic [VW-1:0]  r_pixel_y;

  logic           w_tick, w_h_last, w_v_last, w_eol, w_visible, w_line_start;
  logic [1:0]     w_h_state_nxt, w_v_state_nxt;
  logic [HCW-1:0] w_h_cnt_nxt;
  logic [VCW-1:0] w_v_cnt_nxt;

  assign w_tick = (r_div == DW'(CLK_DIV - 1));

  // Horizontal phase FSM: next state and end-of-line detect
  always_comb begin
    w_h_last      = 1'b0;
    w_h_state_nxt = r_h_state;
    w_h_cnt_nxt   = r_h_cnt;
    case (r_h_state)
      ST_ACTIVE: w_h_last = (r_h_cnt == HCW'(H_ACTIVE - 1));
      ST_FRONT:  w_h_last = (r_h_cnt == HCW'(H_FP - 1));
      ST_SYNC:   w_h_last = (r_h_cnt == HCW'(H_SYNC - 1));
      default:   w_h_last = (r_h_cnt == HCW'(H_BP - 1));
    endcase
    if (w_tick) begin
      if (w_h_last) begin
        w_h_cnt_nxt = '0;
        case (r_h_state)
          ST_ACTIVE: w_h_state_nxt = ST_FRONT;
          ST_FRONT:  w_h_state_nxt = ST_SYNC;
          ST_SYNC:   w_h_state_nxt = ST_BACK;
          default:   w_h_state_nxt = ST_ACTIVE;
        endcase
      end else begin
        w_h_cnt_nxt = r_h_cnt + HCW'(1);
      end
    end
  end

  assign w_eol = w_tick && (r_h_state == ST_BACK) && w_h_last;

  // Vertical phase FSM, stepped once per line
  always_comb begin
    w_v_last      = 1'b0;
    w_v_state_nxt = r_v_state;
    w_v_cnt_nxt   = r_v_cnt;
    case (r_v_state)
      ST_ACTIVE: w_v_last = (r_v_cnt == VCW'(V_ACTIVE - 1));
      ST_FRONT:  w_v_last = (r_v_cnt == VCW'(V_FP - 1));
      ST_SYNC:   w_v_last = (r_v_cnt == VCW'(V_SYNC - 1));
      default:   w_v_last = (r_v_cnt == VCW'(V_BP - 1));
    endcase
    if (w_eol) begin
      if (w_v_last) begin
        w_v_cnt_nxt = '0;
        case (r_v_state)
          ST_ACTIVE: w_v_state_nxt = ST_FRONT;
          ST_FRONT:  w_v_state_nxt = ST_SYNC;
          ST_SYNC:   w_v_state_nxt = ST_BACK;
          default:   w_v_state_nxt = ST_ACTIVE;
        endcase
      end else begin
        w_v_cnt_nxt = r_v_cnt + VCW'(1);
      end
    end
  end

  assign w_visible    = (r_h_state == ST_ACTIVE) && (r_v_state == ST_ACTIVE);
  assign w_line_start = (r_h_state == ST_ACTIVE) && (r_h_cnt == '0);

  // Presented outputs are taken from the pre-advance position, one tick behind the scan
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_div         <= '0;
      r_h_state     <= ST_ACTIVE;
      r_v_state     <= ST_ACTIVE;
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_pixel_tick  <= 1'b0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_video_on    <= 1'b0;
      r_pixel_x     <= '0;
      r_pixel_y     <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_tick ? '0 : r_div + DW'(1);
      r_h_state     <= w_h_state_nxt;
      r_h_cnt       <= w_h_cnt_nxt;
      r_v_state     <= w_v_state_nxt;
      r_v_cnt       <= w_v_cnt_nxt;
      r_pixel_tick  <= w_tick;
      r_line_start  <= w_tick && w_line_start;
      r_frame_start <= w_tick && w_line_start && (r_v_state == ST_ACTIVE) && (r_v_cnt == '0);
      if (w_tick) begin
        r_hsync    <= (r_h_state == ST_SYNC) ? HS_POL : ~HS_POL;
        r_vsync    <= (r_v_state == ST_SYNC) ? VS_POL : ~VS_POL;
        r_video_on <= w_visible;
        r_pixel_x  <= w_visible ? HW'(r_h_cnt) : '0;
        r_pixel_y  <= w_visible ? VW'(r_v_cnt) : '0;
      end
    end
  end

  assign o_pixel_tick  = r_pixel_tick;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_video_on    = r_video_on;
  assign o_pixel_x     = r_pixel_x;
  assign o_pixel_y     = r_pixel_y;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench for vga_timing_controller using a reduced raster
// (15 ticks/line, 8 lines/frame, CLK_DIV=2) so several frames fit in a short run.
module tb_vga_timing_controller;

  localparam int CLK_DIV = 2;
  localparam int H_TOT   = 15;
  localparam int V_TOT   = 8;
  localparam int HW      = 11;
  localparam int VW      = 10;

  logic          Clk;
  logic          Reset;
  logic          o_pixel_tick, o_hsync, o_vsync, o_video_on, o_line_start, o_frame_start;
  logic [HW-1:0] o_pixel_x;
  logic [VW-1:0] o_pixel_y;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;
  int last_ls = -1;
  int last_fs = -1;
  int cur_t   = 0;
  int gap;

  vga_timing_controller #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .HW(HW), .VW(VW)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .o_pixel_tick(o_pixel_tick), .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_video_on(o_video_on), .o_pixel_x(o_pixel_x), .o_pixel_y(o_pixel_y),
    .o_line_start(o_line_start), .o_frame_start(o_frame_start)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int want);
    cmp_cnt++;
    assert (obs === want) else begin
      err_cnt++;
      $error("FAIL %s (tick %0d): observed %0d expected %0d", tag, cur_t, obs, want);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tick"},  int'(o_pixel_tick),  0);
    chk({tag, "_hsync"}, int'(o_hsync),       1);
    chk({tag, "_vsync"}, int'(o_vsync),       1);
    chk({tag, "_video"}, int'(o_video_on),    0);
    chk({tag, "_x"},     int'(o_pixel_x),     0);
    chk({tag, "_y"},     int'(o_pixel_y),     0);
    chk({tag, "_ls"},    int'(o_line_start),  0);
    chk({tag, "_fs"},    int'(o_frame_start), 0);
  endtask

  // Expected presented values for raster tick t, derived from phase boundaries
  // H: active 0-7, front 8-9, sync 10-12, back 13-14; V: active 0-3, front 4, sync 5-6, back 7
  task automatic chk_pos(input int t);
    int hx, vy;
    bit vis;
    cur_t = t;
    hx  = t % H_TOT;
    vy  = (t / H_TOT) % V_TOT;
    vis = (hx < 8) && (vy < 4);
    chk("pixel_tick", int'(o_pixel_tick), 1);
    chk("video_on",   int'(o_video_on),   int'(vis));
    chk("pixel_x",    int'(o_pixel_x),    vis ? hx : 0);
    chk("pixel_y",    int'(o_pixel_y),    vis ? vy : 0);
    chk("hsync",      int'(o_hsync),      (hx >= 10 && hx <= 12) ? 0 : 1);
    chk("vsync",      int'(o_vsync),      (vy >= 5 && vy <= 6) ? 0 : 1);
    chk("line_start", int'(o_line_start), int'(hx == 0));
    chk("frame_start", int'(o_frame_start), int'(hx == 0 && vy == 0));
    if (hx == 0) begin
      if (last_ls >= 0) chk("ls_period", cyc - last_ls, H_TOT * CLK_DIV);
      last_ls = cyc;
      if (vy == 0) begin
        if (last_fs >= 0) chk("fs_period", cyc - last_fs, H_TOT * V_TOT * CLK_DIV);
        last_fs = cyc;
      end
    end
  endtask

  // Advance to the next pixel_tick within a bounded budget; pulses must be low in between
  task automatic next_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
      if (!o_pixel_tick) begin
        chk("gap_ls", int'(o_line_start),  0);
        chk("gap_fs", int'(o_frame_start), 0);
      end
    end while (!o_pixel_tick && n < 4 * CLK_DIV);
  endtask

  initial begin
    Reset = 1'b1;
    repeat (5) step();
    chk_idle("reset");

    Reset = 1'b0;
    step();
    chk("first_edge_tick", int'(o_pixel_tick), 0);
    step();
    chk_pos(0);

    step();
    chk("hold_tick",  int'(o_pixel_tick), 0);
    chk("hold_video", int'(o_video_on),   1);
    chk("hold_x",     int'(o_pixel_x),    0);
    chk("hold_ls",    int'(o_line_start), 0);
    next_tick(gap);
    chk("gap_after_hold", gap, 1);
    chk_pos(1);

    // Two full frames plus the wrap, then into line 2 up to hsync (x-tick 11)
    for (int t = 2; t <= 2 * H_TOT * V_TOT + 2 * H_TOT + 11; t++) begin
      next_tick(gap);
      chk("tick_gap", gap, CLK_DIV);
      chk_pos(t);
    end
    chk("mid_hsync_active", int'(o_hsync), 0);

    Reset = 1'b1;
    step();
    chk_idle("rst_mid");
    Reset = 1'b0;
    last_ls = -1;
    last_fs = -1;
    step();
    chk("rst_first_edge_tick", int'(o_pixel_tick), 0);
    step();
    chk_pos(0);
    for (int t = 1; t <= 2 * H_TOT; t++) begin
      next_tick(gap);
      chk("tick_gap_rst", gap, CLK_DIV);
      chk_pos(t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
